gtclk_ctrl: RTL

Clock-gating controller that sequences the `io_ena` input of the `gtclk` clock-gate cell. Up to N requesters share one gated clock domain. The controller opens the gate when any requester (or a software force bit) asks for it, and reports a clock-stable ready after a fixed settle delay. After a programmable idle hysteresis it closes the gate again. It runs on the free-running (ungated) clock, and its `io_ena` connects directly to the `gtclk` enable.

---
 rtl/gtclk_ctrl.sv | 114 +++++++++++
 1 files changed

// File: rtl/gtclk_ctrl.sv
// Enable sequencer for a gtclk clock-gate cell: opens the gate on any request,
// flags ready after a settle delay, and closes it again after an idle hysteresis.
module gtclk_ctrl #(
    parameter int N           = 4,
    parameter int WAKE_CYCLES = 2,
    parameter int IDLE_CYCLES = 16
) (
    input  logic         clock,
    input  logic         reset,
    input  logic [N-1:0] io_req,
    input  logic         io_force,
    output logic         io_ena,
    output logic         io_rdy,
    output logic [1:0]   io_state,
    output logic [15:0]  io_gates
);

    localparam int WW = (WAKE_CYCLES > 0) ? $clog2(WAKE_CYCLES + 1) : 1;
    localparam int IW = (IDLE_CYCLES > 0) ? $clog2(IDLE_CYCLES + 1) : 1;
    localparam logic [WW-1:0] WAKE_LAST = WW'(WAKE_CYCLES - 1);
    localparam logic [IW-1:0] IDLE_LAST = IW'(IDLE_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_OFF   = 2'd0,
        ST_WAKE  = 2'd1,
        ST_ON    = 2'd2,
        ST_DRAIN = 2'd3
    } state_e;

    state_e        state_q, state_d;
    logic [WW-1:0] wcnt_q, wcnt_d;
    logic [IW-1:0] icnt_q, icnt_d;
    logic [15:0]   gates_q, gates_d;
    logic          ena_q, ena_d;
    logic          rdy_q, rdy_d;
    logic          any_req;

    assign any_req = (|io_req) | io_force;

    always_comb begin
        state_d = state_q;
        wcnt_d  = wcnt_q;
        icnt_d  = icnt_q;
        gates_d = gates_q;
        case (state_q)
            ST_OFF: begin
                if (any_req) begin
                    wcnt_d  = '0;
                    state_d = (WAKE_CYCLES == 0) ? ST_ON : ST_WAKE;
                end
            end
            ST_WAKE: begin
                // Requests are ignored here: a started wake always completes.
                if (wcnt_q == WAKE_LAST) begin
                    state_d = ST_ON;
                end else begin
                    wcnt_d = wcnt_q + WW'(1);
                end
            end
            ST_ON: begin
                if (!any_req) begin
                    icnt_d = '0;
                    if (IDLE_CYCLES == 0) begin
                        // Zero hysteresis skips DRAIN but is still a gating event.
                        state_d = ST_OFF;
                        if (gates_q != 16'hFFFF) gates_d = gates_q + 16'd1;
                    end else begin
                        state_d = ST_DRAIN;
                    end
                end
            end
            ST_DRAIN: begin
                if (any_req) begin
                    state_d = ST_ON;
                    icnt_d  = '0;
                end else if (icnt_q == IDLE_LAST) begin
                    state_d = ST_OFF;
                    if (gates_q != 16'hFFFF) gates_d = gates_q + 16'd1;
                end else begin
                    icnt_d = icnt_q + IW'(1);
                end
            end
            default: state_d = ST_OFF;
        endcase
        // Outputs are registered copies of the next-state decode, so they always
        // match the decode of the state register.
        ena_d = (state_d != ST_OFF);
        rdy_d = (state_d == ST_ON) || (state_d == ST_DRAIN);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= ST_OFF;
            wcnt_q  <= '0;
            icnt_q  <= '0;
            gates_q <= '0;
            ena_q   <= 1'b0;
            rdy_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            wcnt_q  <= wcnt_d;
            icnt_q  <= icnt_d;
            gates_q <= gates_d;
            ena_q   <= ena_d;
            rdy_q   <= rdy_d;
        end
    end

    assign io_ena   = ena_q;
    assign io_rdy   = rdy_q;
    assign io_state = state_q;
    assign io_gates = gates_q;

endmodule
